// File: rtl/shift_add_mult_ctrl_pkg.sv
// shift_add_mult_ctrl_pkg: controller state type and operand-width rule for the shift-add multiplier
package shift_add_mult_ctrl_pkg;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;
    function automatic bit width_ok(input int w);
        return w > 0 && w % 4 == 0;
    endfunction
endpackage

// File: rtl/shift_add_mult_ctrl_cla.sv
// shift_add_mult_ctrl_cla: 4-bit carry-lookahead slice and the WIDTH-bit block-ripple adder built from it
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [3:0] g, p, c;
    always_comb begin
        g = a & b;
        p = a ^ b;
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
        c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);
        sum = p ^ c;
    end
endmodule

module cla_adder_w #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int N = WIDTH / 4;
    logic [N:0] c;
    assign c[0] = c_in;
    for (genvar i = 0; i < N; i++) begin : g_slice
        cla4 u_slice (
            .a    (a[4*i +: 4]),
            .b    (b[4*i +: 4]),
            .c_in (c[i]),
            .sum  (sum[4*i +: 4]),
            .c_out(c[i+1])
        );
    end
    assign c_out = c[N];
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: multi-cycle unsigned shift-add multiplier sequencing one shared CLA adder
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("WIDTH must be a positive multiple of 4");
    end
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, m_q, m_d, sum;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               carry_q, carry_d, co, busy_q, busy_d, done_q, done_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH:0]   ext;
    cla_adder_w #(.WIDTH(WIDTH)) u_add (
        .a    (acc_q),
        .b    (q_q[0] ? m_q : '0),
        .c_in (1'b0),
        .sum  (sum),
        .c_out(co)
    );
    // Carry-out is kept as the top bit so the shifted-in ACC MSB never loses it.
    assign ext = {co, sum, q_q};
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        prod_d  = prod_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                m_d     = multiplicand;
                q_d     = multiplier;
                acc_d   = '0;
                cnt_d   = CW'(WIDTH);
                carry_d = 1'b0;
                state_d = S_RUN;
            end
        end else if (state_q == S_RUN) begin
            {acc_d, q_d} = ext[2*WIDTH:1];
            carry_d      = co;
            cnt_d        = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = S_DONE;
                prod_d  = ext[2*WIDTH:1];
            end
        end else begin
            state_d = S_IDLE;
        end
        busy_d = state_d == S_RUN || state_d == S_DONE;
        done_d = state_d == S_DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;
endmodule
